// File: rtl/keccak_absorb_mask_pkg.sv
// Shared Keccak constants: lane geometry, two-share state layout, SHA-3 rate table.
// Pure declarations; no clocked logic.
package keccak_absorb_mask_pkg;

  localparam int KECCAK_LANE_W = 64;
  localparam int SHARE_W       = 1600;
  localparam int NUM_LANES     = SHARE_W / KECCAK_LANE_W;
  localparam int STATE_W       = 2 * SHARE_W;

  // Rate in lanes for each SHA-3 / SHAKE variant
  localparam int RATE_SHA3_224 = 18;
  localparam int RATE_SHA3_256 = 17;
  localparam int RATE_SHA3_384 = 13;
  localparam int RATE_SHA3_512 = 9;
  localparam int RATE_SHAKE128 = 21;
  localparam int RATE_SHAKE256 = 17;

  localparam int SHARE0_OFS = 0;
  localparam int SHARE1_OFS = SHARE_W;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  typedef logic [KECCAK_LANE_W-1:0] lane_t;

  function automatic int lane_lsb(input int share_ofs, input int k);
    return share_ofs + k * KECCAK_LANE_W;
  endfunction

endpackage

// File: rtl/keccak_absorb_mask_lane.sv
// Splits one message lane into two Boolean shares with one fresh random word.
// Combinational, no backpressure; share0 = msg ^ rnd, share1 = rnd.
module keccak_absorb_mask_lane
  import keccak_absorb_mask_pkg::*;
#(
  parameter int W = KECCAK_LANE_W
) (
  input  logic [W-1:0] msg,
  input  logic [W-1:0] rnd,
  output logic [W-1:0] share0,
  output logic [W-1:0] share1
);

  assign share0 = msg ^ rnd;
  assign share1 = rnd;

endmodule

// File: rtl/keccak_absorb_mask.sv
// Lane-serial masked absorb: buffers one rate block as two shares, XORs it into the state.
// One lane/cycle while filling; block held until block_ready_i, no lanes accepted meanwhile.
module keccak_absorb_mask
  import keccak_absorb_mask_pkg::*;
#(
  parameter int RATE_LANES = 17,
  parameter int LANE_W     = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 msg_valid_i,
  output logic                 msg_ready_o,
  input  logic [LANE_W-1:0]    msg_data_i,
  input  logic                 msg_last_i,
  input  logic                 rnd_valid_i,
  input  logic [LANE_W-1:0]    rnd_i,
  output logic                 rnd_ready_o,
  input  logic [STATE_W-1:0]   state_shares_i,
  output logic                 block_valid_o,
  input  logic                 block_ready_i,
  output logic [STATE_W-1:0]   state_shares_o
);

  localparam int CNT_W = $clog2(RATE_LANES + 1);
  localparam int BUF_W = RATE_LANES * LANE_W;

  logic [0:0]        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [BUF_W-1:0]  buf0_q;
  logic [BUF_W-1:0]  buf1_q;
  logic              accept;
  logic              last_lane;
  logic [LANE_W-1:0] mask_s0;
  logic [LANE_W-1:0] mask_s1;

  // Randomness gates acceptance so every lane is masked by its own word
  assign msg_ready_o   = (state_q == ST_FILL) && rnd_valid_i;
  assign accept        = msg_valid_i && msg_ready_o;
  assign rnd_ready_o   = accept;
  assign block_valid_o = (state_q == ST_HOLD);
  assign last_lane     = msg_last_i || (cnt_q == CNT_W'(RATE_LANES - 1));

  keccak_absorb_mask_lane #(
    .W (LANE_W)
  ) u_lane_mask (
    .msg    (msg_data_i),
    .rnd    (rnd_i),
    .share0 (mask_s0),
    .share1 (mask_s1)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_FILL;
      cnt_q   <= '0;
      buf0_q  <= '0;
      buf1_q  <= '0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (accept) begin
            for (int k = 0; k < RATE_LANES; k++) begin
              if (cnt_q == CNT_W'(k)) begin
                buf0_q[k*LANE_W +: LANE_W] <= mask_s0;
                buf1_q[k*LANE_W +: LANE_W] <= mask_s1;
              end
            end
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_lane) begin
              state_q <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (block_ready_i) begin
            state_q <= ST_FILL;
            cnt_q   <= '0;
            buf0_q  <= '0;
            buf1_q  <= '0;
          end
        end
        default: state_q <= ST_FILL;
      endcase
    end
  end

  // Unfilled buffer lanes are zero, so capacity and unwritten rate lanes pass through
  always_comb begin
    state_shares_o = state_shares_i;
    for (int k = 0; k < RATE_LANES; k++) begin
      state_shares_o[lane_lsb(SHARE0_OFS, k) +: LANE_W] =
        state_shares_i[lane_lsb(SHARE0_OFS, k) +: LANE_W] ^ buf0_q[k*LANE_W +: LANE_W];
      state_shares_o[lane_lsb(SHARE1_OFS, k) +: LANE_W] =
        state_shares_i[lane_lsb(SHARE1_OFS, k) +: LANE_W] ^ buf1_q[k*LANE_W +: LANE_W];
    end
  end

endmodule

// File: tb/tb_keccak_absorb_mask.sv
// Bench for keccak_absorb_mask: vector table, directed corner sequences, randomized traffic.
module tb_keccak_absorb_mask;
  localparam int RL = 17;
  localparam int SW = 1600;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          msg_valid_i, msg_last_i, rnd_valid_i, block_ready_i;
  logic [63:0]   msg_data_i, rnd_i;
  logic [3199:0] state_shares_i, state_shares_o;
  logic          msg_ready_o, rnd_ready_o, block_valid_o;

  always #5 clk_i = ~clk_i;

  keccak_absorb_mask #(.RATE_LANES(RL), .LANE_W(64)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .msg_valid_i    (msg_valid_i),
    .msg_ready_o    (msg_ready_o),
    .msg_data_i     (msg_data_i),
    .msg_last_i     (msg_last_i),
    .rnd_valid_i    (rnd_valid_i),
    .rnd_i          (rnd_i),
    .rnd_ready_o    (rnd_ready_o),
    .state_shares_i (state_shares_i),
    .block_valid_o  (block_valid_o),
    .block_ready_i  (block_ready_i),
    .state_shares_o (state_shares_o)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: the lanes accepted so far in this block, in arrival order
  logic [63:0] m_msg [25];
  logic [63:0] m_rnd [25];
  int          m_cnt;
  bit          m_hold;

  typedef struct {
    logic [63:0] msg;
    logic [63:0] rnd;
    logic        last;
    logic        exp_bv;
  } vec_t;
  vec_t tbl [RL];

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [63:0] lane_of(input logic [3199:0] v, input int sh, input int k);
    return v[sh*SW + k*64 +: 64];
  endfunction

  function automatic logic [3199:0] model_out();
    logic [3199:0] r;
    r = state_shares_i;
    for (int k = 0; k < m_cnt; k++) begin
      r[k*64 +: 64]      = r[k*64 +: 64] ^ m_msg[k] ^ m_rnd[k];
      r[SW + k*64 +: 64] = r[SW + k*64 +: 64] ^ m_rnd[k];
    end
    return r;
  endfunction

  task automatic model_clear();
    m_cnt  = 0;
    m_hold = 0;
    for (int k = 0; k < 25; k++) begin
      m_msg[k] = '0;
      m_rnd[k] = '0;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_state(input string name);
    logic [3199:0] e;
    e = model_out();
    vectors++;
    if (state_shares_o !== e) begin
      miscompares++;
      for (int i = 0; i < 50; i++) begin
        if (state_shares_o[i*64 +: 64] !== e[i*64 +: 64]) begin
          $display("FAIL %s: share%0d lane %0d got %h expected %h", name, i / 25, i % 25,
                   state_shares_o[i*64 +: 64], e[i*64 +: 64]);
          break;
        end
      end
    end
  endtask

  // Check outputs mid-cycle, advance the model with the inputs seen at the edge
  task automatic cycle();
    @(negedge clk_i);
    chk1("msg_ready", msg_ready_o, !m_hold && rnd_valid_i);
    chk1("rnd_ready", rnd_ready_o, !m_hold && rnd_valid_i && msg_valid_i);
    chk1("block_valid", block_valid_o, m_hold);
    check_state("state_out");
    if (!m_hold && msg_valid_i && rnd_valid_i) begin
      m_msg[m_cnt] = msg_data_i;
      m_rnd[m_cnt] = rnd_i;
      m_cnt++;
      if (m_cnt == RL || msg_last_i) m_hold = 1;
    end else if (m_hold && block_ready_i) begin
      model_clear();
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic lane(input logic [63:0] msg, input logic [63:0] rnd, input logic last);
    msg_valid_i = 1'b1;
    rnd_valid_i = 1'b1;
    msg_data_i  = msg;
    rnd_i       = rnd;
    msg_last_i  = last;
    cycle();
    msg_valid_i = 1'b0;
    rnd_valid_i = 1'b0;
    msg_last_i  = 1'b0;
  endtask

  task automatic handoff();
    block_ready_i = 1'b1;
    cycle();
    block_ready_i = 1'b0;
  endtask

  logic [3199:0] held;
  logic [63:0]   r0;

  initial begin
    rst_ni = 1'b0; msg_valid_i = 1'b0; msg_last_i = 1'b0; rnd_valid_i = 1'b0;
    block_ready_i = 1'b0; msg_data_i = '0; rnd_i = '0; state_shares_i = '0;
    model_clear();
    for (int k = 0; k < RL; k++) begin
      tbl[k].msg    = 64'(k);
      tbl[k].rnd    = 64'hA5A5_0000_0000_0000 + 64'(k);
      tbl[k].last   = 1'b0;
      tbl[k].exp_bv = (k == RL - 1);
    end

    // Reset values
    #2;
    chk1("rst_block_valid", block_valid_o, 1'b0);
    chk1("rst_rnd_ready", rnd_ready_o, 1'b0);
    chk1("rst_msg_ready_lo", msg_ready_o, 1'b0);
    chk("rst_state_lane0", lane_of(state_shares_o, 0, 0), 64'h0);
    rnd_valid_i = 1'b1;
    #1;
    chk1("rst_msg_ready_follows_rnd", msg_ready_o, 1'b1);
    rnd_valid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Full block from the vector table
    for (int k = 0; k < RL; k++) begin
      msg_valid_i = 1'b1; rnd_valid_i = 1'b1;
      msg_data_i = tbl[k].msg; rnd_i = tbl[k].rnd; msg_last_i = tbl[k].last;
      cycle();
      #3;
      chk1("t1_block_valid", block_valid_o, tbl[k].exp_bv);
    end
    msg_valid_i = 1'b0; rnd_valid_i = 1'b0;
    for (int k = 0; k < 25; k++) begin
      if (k < RL) begin
        chk("t1_unmasked", lane_of(state_shares_o, 0, k) ^ lane_of(state_shares_o, 1, k), tbl[k].msg);
        chk("t1_share1", lane_of(state_shares_o, 1, k), tbl[k].rnd);
      end else begin
        chk("t1_cap_share0", lane_of(state_shares_o, 0, k), 64'h0);
        chk("t1_cap_share1", lane_of(state_shares_o, 1, k), 64'h0);
      end
    end
    handoff();

    // Zero block into an all-ones state
    state_shares_i = {{SW{1'b0}}, {SW{1'b1}}};
    for (int k = 0; k < RL; k++) lane(64'h0, rnd64(), 1'b0);
    #3;
    for (int k = 0; k < 25; k++)
      chk("t2_unmasked", lane_of(state_shares_o, 0, k) ^ lane_of(state_shares_o, 1, k), '1);
    handoff();

    // Early last on lane 3
    for (int i = 0; i < 100; i++) state_shares_i[i*32 +: 32] = $urandom();
    for (int k = 0; k < 4; k++) lane(rnd64(), rnd64(), k == 3);
    #3;
    chk1("t3_hold", block_valid_o, 1'b1);
    for (int k = 4; k < RL; k++) begin
      chk("t3_pass_s0", lane_of(state_shares_o, 0, k), lane_of(state_shares_i, 0, k));
      chk("t3_pass_s1", lane_of(state_shares_o, 1, k), lane_of(state_shares_i, 1, k));
    end
    handoff();

    // Randomness toggling with message always valid
    msg_valid_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rnd_valid_i = (i % 2 == 1);
      msg_data_i = rnd64(); rnd_i = rnd64(); msg_last_i = 1'b0;
      cycle();
    end
    #3;
    chk1("t4_not_full", block_valid_o, 1'b0);
    for (int k = 8; k < RL; k++) lane(rnd64(), rnd64(), 1'b0);

    // Consumer stalls for 10 cycles with a message pending
    msg_valid_i = 1'b1; rnd_valid_i = 1'b1;
    held = state_shares_o;
    for (int i = 0; i < 10; i++) begin
      msg_data_i = rnd64(); rnd_i = rnd64();
      cycle();
      chk1("t5_stable", state_shares_o === held, 1'b1);
    end
    handoff();
    r0 = rnd64();
    msg_valid_i = 1'b1; rnd_valid_i = 1'b1; msg_data_i = rnd64(); rnd_i = r0;
    cycle();
    msg_valid_i = 1'b0; rnd_valid_i = 1'b0;
    #3;
    chk("t5_lane0_share1", lane_of(state_shares_o, 1, 0) ^ lane_of(state_shares_i, 1, 0), r0);

    // Reset mid-block discards the partial buffers
    for (int k = 1; k < 9; k++) lane(rnd64(), rnd64(), 1'b0);
    rst_ni = 1'b0; rnd_valid_i = 1'b1;
    #2;
    chk1("t6_block_valid", block_valid_o, 1'b0);
    chk1("t6_rnd_ready", rnd_ready_o, 1'b0);
    chk1("t6_msg_ready", msg_ready_o, 1'b1);
    chk1("t6_state_passthru", state_shares_o === state_shares_i, 1'b1);
    model_clear();
    rnd_valid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    for (int k = 0; k < 3; k++) lane(rnd64(), rnd64(), 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      msg_valid_i   = ($urandom_range(3) != 0);
      rnd_valid_i   = ($urandom_range(3) != 0);
      msg_last_i    = ($urandom_range(7) == 0);
      block_ready_i = ($urandom_range(2) == 0);
      msg_data_i    = rnd64();
      rnd_i         = rnd64();
      if (!m_hold && $urandom_range(9) == 0)
        state_shares_i[$urandom_range(99)*32 +: 32] = $urandom();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keccak_absorb_mask.md
# keccak_absorb_mask

Lane-serial masked absorb front end for the two-share Keccak core. Accepts 64-bit message lanes with a valid/ready handshake, splits each lane into two Boolean shares using one fresh 64-bit random word per lane, and buffers a full rate block. On handoff it XORs the buffered shares into the current two-share state. It sits upstream of the round registers and produces the same 2×1600-bit share layout that the round datapath returns after chi/iota compression.

## Interface
- RATE_LANES, 17: lanes per block (17 = SHA3-256 rate 1088 bits); legal range 1..25.
- LANE_W, 64: lane width; fixed at 64, present for readability only.

- clk_i  in  1  rising-edge clock
- rst_ni  in  1  asynchronous, active-low reset
- msg_valid_i  in  1  message lane valid
- msg_ready_o  out  1  message lane accepted this cycle when high with msg_valid_i
- msg_data_i  in  64  message lane (already padded upstream)
- msg_last_i  in  1  final lane of the current block; sampled on accept
- rnd_valid_i  in  1  fresh randomness available
- rnd_i  in  64  fresh random word
- rnd_ready_o  out  1  randomness consumed this cycle
- state_shares_i  in  2*1600  current masked state; share0 [1599:0], share1 [3199:1600]
- block_valid_o  out  1  absorbed state on state_shares_o is valid
- block_ready_i  in  1  consumer (round logic) takes the block
- state_shares_o  out  2*1600  state with block absorbed, same layout as state_shares_i

## Operation
- Lane k of a share occupies bits [64k+63 : 64k] of that share's 1600-bit field.
- FSM states: FILL, HOLD.
- FILL: msg_ready_o = rnd_valid_i. Accept = msg_valid_i & msg_ready_o; rnd_ready_o = accept.
  - On accept at lane counter k: buf0[k] <= msg_data_i ^ rnd_i; buf1[k] <= rnd_i; counter increments.
  - Go to HOLD when accepted lane has k == RATE_LANES-1 or msg_last_i = 1.
  - Early last (k < RATE_LANES-1): unfilled lanes stay 0 in both buffers (absorb of zero, state lanes unchanged).
- HOLD: msg_ready_o = 0, rnd_ready_o = 0, block_valid_o = 1.
  - state_shares_o: share0 lane k = state_shares_i share0 lane k ^ buf0[k], share1 lane k = state_shares_i share1 lane k ^ buf1[k] for k < RATE_LANES; capacity lanes pass through unchanged.
  - On block_ready_i: clear buf0, buf1 and counter to 0, go to FILL.
- In FILL, state_shares_o = state_shares_i ^ buffers as above (combinational), but block_valid_o = 0; consumers ignore it.
- No lane ever combines msg_data_i with both shares' buffers unmasked; rnd_i is never reused (one word per accept).
- msg_data_i/msg_last_i/rnd_i must be stable only in the accept cycle.

## Timing
- Reset (rst_ni low, async): state FILL, counter 0, buf0 = buf1 = 0, block_valid_o = 0, rnd_ready_o = 0; msg_ready_o = rnd_valid_i (combinational, 0 while rnd_valid_i = 0).
- One lane per cycle maximum; full block fills in RATE_LANES cycles at full throughput.
- block_valid_o rises the cycle after the final accept; falls the cycle after block_ready_i handshake.
- Handoff-to-next-accept: 1 cycle (FILL entered after the block_ready_i edge).
- block_valid_o held until block_ready_i; no lane accepted while HOLD.
- msg_valid_i with rnd_valid_i = 0: stall, no state change.
- Reset mid-block discards the partial buffers; no partial output.
- state_shares_o to state_shares_i path is combinational; state_shares_i must be stable throughout HOLD.

## Structure
- Shared keccak package: RATE_LANES per SHA-3 variant constants, lane width, share layout offsets (SHARE_W = 1600), lane index function.
- One sub-module natural: keccak_lane_mask (one lane: msg, rnd -> share0, share1), instantiated once in the accept path.
- FSM, lane counter and buffers in the top module; counter width $clog2(RATE_LANES+1).

## Test plan
- Reset then 17 lanes, msg lane k = k, rnd = 64'hA5A5_0000_0000_0000 + k, state_shares_i = 0 -> block_valid_o high one cycle after 17th accept; share0 ^ share1 lane k = k, share1 lane k = rnd_k, lanes 17..24 = 0.
- Nonzero state_shares_i (share0 = all 1s, share1 = 0), one block of zeros -> unmasked state (share0^share1) remains all 1s in every lane.
- msg_last_i on lane 3 (4 lanes) -> HOLD after 4 accepts; lanes 4..16 of output equal state_shares_i lanes.
- rnd_valid_i toggled 0/1 every cycle with msg_valid_i held high -> exactly one accept per rnd_valid_i = 1 cycle, rnd_ready_o == accept, no lane skipped.
- block_ready_i held low 10 cycles in HOLD, msg_valid_i high -> msg_ready_o = 0 throughout, output stable; block_ready_i pulse -> next accept one cycle later into lane 0.
- rst_ni asserted after lane 8 -> outputs at reset values immediately; next block starts at lane 0 with buffers zero.
